// File: rtl/tmr_cap_filt_pkg.sv
// Shared constants for the timer capture input filter: edge-select codes and filter FSM states.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package tmr_cap_filt_pkg;

    // Edge-select codes driven on edge_sel_i
    localparam logic [1:0] TMR_CAP_EDGE_NONE = 2'b00;
    localparam logic [1:0] TMR_CAP_EDGE_RISE = 2'b01;
    localparam logic [1:0] TMR_CAP_EDGE_FALL = 2'b10;
    localparam logic [1:0] TMR_CAP_EDGE_BOTH = 2'b11;

    // Filter FSM state encodings
    localparam logic [0:0] TMR_FILT_STABLE = 1'b0;
    localparam logic [0:0] TMR_FILT_PEND   = 1'b1;

    // True when an accepted level change towards new_lvl is selected by sel.
    // new_lvl=1 means a rising edge, new_lvl=0 a falling edge.
    function automatic logic edge_qual(input logic [1:0] sel, input logic new_lvl);
        logic q;
        if (new_lvl)
            q = (sel == TMR_CAP_EDGE_RISE) || (sel == TMR_CAP_EDGE_BOTH);
        else
            q = (sel == TMR_CAP_EDGE_FALL) || (sel == TMR_CAP_EDGE_BOTH);
        return q;
    endfunction

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk_i domain.
// Latency: STAGES clocks from d_i to q_o.
// Backpressure: none; free-running, samples every clock.
//
// Ports: clk_i/rst_i clock and async active-high reset, d_i async input, q_o synchronised output.
module cdc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            sync_q <= '0;
        else
            sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tmr_cap_tick.sv
// Sample-tick generator: one tick every smp_div_i+1 clocks while enabled.
// Latency: tick is combinational from the divider count; first tick smp_div_i+1 clocks after enable.
// Backpressure: none; free-running while en_i is high, held at zero otherwise.
//
// Ports: clk_i/rst_i clock and async active-high reset, en_i enable,
//        smp_div_i divide value, tick_o one-clock sample strobe.
module tmr_cap_tick #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] smp_div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] div_cnt;

    // >= rather than == so that shrinking smp_div_i mid-count wraps on the
    // next clock instead of running all the way round the counter.
    assign tick_o = en_i && (div_cnt >= smp_div_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            div_cnt <= '0;
        else if (!en_i || tick_o)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

endmodule

// File: rtl/tmr_cap_filt.sv
// Capture-pin conditioner: synchronise, sample on a tick, reject short pulses, emit prescaled edge events.
// Latency: with smp_div_i=0, cap_o follows a stable cap_i change after SYNC_STAGE+max(filt_len_i,1) clocks.
// Backpressure: none; evt_o is a one-clock pulse with no handshake.
//
// Ports: clk_i/rst_i clock and async active-high reset; en_i block enable;
//        smp_div_i tick divider; filt_len_i consecutive-sample length (0 acts as 1);
//        edge_sel_i edge select; evt_psc_i event prescale; cap_i raw pin;
//        cap_o filtered level; evt_o qualified-edge event.
// Optional build macro TMR_CAP_FILT_GLITCH_CNT_EN adds glitch_clr_i and the
// saturating 8-bit rejected-glitch counter glitch_cnt_o.
module tmr_cap_filt
    import tmr_cap_filt_pkg::*;
#(
    parameter int SYNC_STAGE = 2,
    parameter int DIV_WIDTH  = 8,
    parameter int FILT_WIDTH = 4,
    parameter int PSC_WIDTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DIV_WIDTH-1:0]  smp_div_i,
    input  logic [FILT_WIDTH-1:0] filt_len_i,
    input  logic [1:0]            edge_sel_i,
    input  logic [PSC_WIDTH-1:0]  evt_psc_i,
    input  logic                  cap_i,
    output logic                  cap_o,
    output logic                  evt_o
`ifdef TMR_CAP_FILT_GLITCH_CNT_EN
    ,
    input  logic                  glitch_clr_i,
    output logic [7:0]            glitch_cnt_o
`endif
);

    logic                  s_smp;
    logic                  tick;
    logic                  lvl_q;
    logic                  evt_q;
    logic [0:0]            state_q;
    logic [FILT_WIDTH-1:0] f_cnt;
    logic [PSC_WIDTH-1:0]  psc_cnt;

    logic [FILT_WIDTH-1:0] filt_eff;
    logic [FILT_WIDTH:0]   f_cnt_inc;
    logic                  differ;
    logic                  accept;
    logic                  qual;

    cdc_sync #(
        .STAGES (SYNC_STAGE)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (cap_i),
        .q_o   (s_smp)
    );

    tmr_cap_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .smp_div_i (smp_div_i),
        .tick_o    (tick)
    );

    // A filter length of 0 behaves like 1 (accept on the first differing tick).
    assign filt_eff  = (filt_len_i == '0) ? {{(FILT_WIDTH-1){1'b0}}, 1'b1} : filt_len_i;
    // One extra bit so the +1 compare cannot wrap at the counter's top value.
    assign f_cnt_inc = {1'b0, f_cnt} + 1'b1;
    assign differ    = (s_smp != lvl_q);
    assign accept    = en_i && tick && differ && (f_cnt_inc >= {1'b0, filt_eff});
    assign qual      = accept && edge_qual(edge_sel_i, s_smp);

    // Filter FSM. When disabled the level simply tracks the synchronised pin,
    // so re-enabling starts from a matched state and cannot fire an event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lvl_q   <= 1'b0;
            f_cnt   <= '0;
            state_q <= TMR_FILT_STABLE;
        end else if (!en_i) begin
            lvl_q   <= s_smp;
            f_cnt   <= '0;
            state_q <= TMR_FILT_STABLE;
        end else if (tick) begin
            if (!differ) begin
                f_cnt   <= '0;
                state_q <= TMR_FILT_STABLE;
            end else if (accept) begin
                lvl_q   <= s_smp;
                f_cnt   <= '0;
                state_q <= TMR_FILT_STABLE;
            end else begin
                f_cnt   <= f_cnt_inc[FILT_WIDTH-1:0];
                state_q <= TMR_FILT_PEND;
            end
        end
    end

    // Edge prescaler. evt_q is registered on the same edge that updates lvl_q,
    // so the event pulse lines up with the first clock of the new cap_o level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc_cnt <= '0;
            evt_q   <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            if (!en_i) begin
                psc_cnt <= '0;
            end else if (qual) begin
                if (psc_cnt >= evt_psc_i) begin
                    evt_q   <= 1'b1;
                    psc_cnt <= '0;
                end else begin
                    psc_cnt <= psc_cnt + 1'b1;
                end
            end
        end
    end

    assign cap_o = lvl_q;
    assign evt_o = evt_q;

`ifdef TMR_CAP_FILT_GLITCH_CNT_EN
    // A glitch is a pending change abandoned because a matching sample arrived.
    logic       glitch;
    logic [7:0] glitch_cnt_q;

    assign glitch = en_i && tick && !differ && (state_q == TMR_FILT_PEND);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            glitch_cnt_q <= 8'd0;
        else if (glitch_clr_i)
            glitch_cnt_q <= 8'd0;
        else if (glitch && (glitch_cnt_q != 8'hFF))
            glitch_cnt_q <= glitch_cnt_q + 8'd1;
    end

    assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_tmr_cap_filt.sv
// Directed bench for the capture-input filter with hand-computed latencies and event counts.
// Latency: n/a.
// Backpressure: n/a.
module tb_tmr_cap_filt;
    import tmr_cap_filt_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] smp_div;
    logic [3:0] filt_len;
    logic [1:0] edge_sel;
    logic [2:0] evt_psc;
    logic       cap_in;
    logic       cap_o;
    logic       evt_o;
`ifdef TMR_CAP_FILT_GLITCH_CNT_EN
    logic       glitch_clr;
    logic [7:0] glitch_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int evt_cnt     = 0;

    always #5 clk = ~clk;

    tmr_cap_filt #(
        .SYNC_STAGE (2),
        .DIV_WIDTH  (8),
        .FILT_WIDTH (4),
        .PSC_WIDTH  (3)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .smp_div_i    (smp_div),
        .filt_len_i   (filt_len),
        .edge_sel_i   (edge_sel),
        .evt_psc_i    (evt_psc),
        .cap_i        (cap_in),
        .cap_o        (cap_o),
        .evt_o        (evt_o)
`ifdef TMR_CAP_FILT_GLITCH_CNT_EN
        ,
        .glitch_clr_i (glitch_clr),
        .glitch_cnt_o (glitch_cnt)
`endif
    );

    // Count event pulses on the falling edge, away from the active edge.
    always @(negedge clk) if (evt_o) evt_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clocks until cap_o reaches lvl; limit+1 when it never does.
    task automatic wait_cap(input logic lvl, input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            step(1);
            if (cap_o == lvl) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int e0;
        int any_flip;

        rst      = 1'b1;
        en       = 1'b0;
        smp_div  = 8'd0;
        filt_len = 4'd3;
        edge_sel = TMR_CAP_EDGE_RISE;
        evt_psc  = 3'd0;
        cap_in   = 1'b0;
`ifdef TMR_CAP_FILT_GLITCH_CNT_EN
        glitch_clr = 1'b0;
`endif
        step(3);
        chk("reset_cap", cap_o, 0);
        chk("reset_evt", evt_o, 0);
        rst = 1'b0;
        en  = 1'b1;
        step(5);

        // Two-clock pulse gives only two differing samples against length 3.
        e0 = evt_cnt;
        cap_in = 1'b1;
        step(2);
        cap_in = 1'b0;
        any_flip = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (cap_o) any_flip = 1;
        end
        chk("short_pulse_lvl", any_flip, 0);
        chk("short_pulse_evt", evt_cnt - e0, 0);

        // Long pulse: 2 sync + 3 samples = 5 clocks, event on the same clock.
        cap_in = 1'b1;
        wait_cap(1'b1, 20, n);
        chk("rise_latency", n, 5);
        chk("rise_evt_aligned", evt_o, 1);
        step(1);
        chk("rise_evt_one_clk", evt_o, 0);
        step(8);
        cap_in = 1'b0;
        wait_cap(1'b0, 20, n);
        chk("fall_latency", n, 5);
        step(2);
        chk("fall_not_selected", evt_cnt - e0, 1);

        // Prescale by 3 on both edges: events on edges 3 and 6 only.
        evt_psc  = 3'd2;
        edge_sel = TMR_CAP_EDGE_BOTH;
        for (int t = 1; t <= 6; t++) begin
            cap_in = ~cap_in;
            e0 = evt_cnt;
            step(8);
            chk($sformatf("psc_edge%0d", t), evt_cnt - e0, (t % 3 == 0) ? 1 : 0);
        end

        // Divider 3, length 2, phase aligned by a one-clock disable:
        // ticks land 4 and 8 clocks after the step -> change after 8 clocks.
        evt_psc  = 3'd0;
        smp_div  = 8'd3;
        filt_len = 4'd2;
        en = 1'b0;
        step(1);
        en = 1'b1;
        cap_in = 1'b1;
        e0 = evt_cnt;
        wait_cap(1'b1, 20, n);
        chk("div3_latency", n, 8);
        chk("div3_evt", evt_o, 1);
        step(12);

        // Shrinking the divide value while div_cnt=2 ticks on the next clock.
        filt_len = 4'd1;
        en = 1'b0;
        step(1);
        en = 1'b1;
        cap_in = 1'b0;
        step(2);
        smp_div = 8'd0;
        wait_cap(1'b0, 20, n);
        chk("div_rewrite_latency", n + 2, 3);
        step(4);

        // Disabled: level tracks the pin after the synchroniser, no events.
        filt_len = 4'd3;
        e0 = evt_cnt;
        en = 1'b0;
        cap_in = 1'b1;
        wait_cap(1'b1, 10, n);
        chk("bypass_latency", n, 3);
        step(2);
        en = 1'b1;
        step(10);
        chk("enable_no_evt", evt_cnt - e0, 0);
        chk("enable_level", cap_o, 1);

        // Async reset while pending with 4 of 8 samples collected.
        filt_len = 4'd8;
        cap_in = 1'b0;
        step(6);
        chk("pend_holds_level", cap_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cap", cap_o, 0);
        chk("async_rst_evt", evt_o, 0);
`ifdef TMR_CAP_FILT_GLITCH_CNT_EN
        chk("async_rst_glitch_cnt", glitch_cnt, 0);
`endif
        step(3);
        rst = 1'b0;
        step(3);
        cap_in = 1'b1;
        wait_cap(1'b1, 20, n);
        chk("post_rst_full_len", n, 10);
        chk("post_rst_evt", evt_o, 1);
        step(4);

`ifdef TMR_CAP_FILT_GLITCH_CNT_EN
        // 300 one-sample glitches against length 2: counter saturates.
        filt_len = 4'd2;
        any_flip = 0;
        for (int g = 0; g < 300; g++) begin
            cap_in = 1'b0;
            step(1);
            cap_in = 1'b1;
            step(4);
            if (!cap_o) any_flip = 1;
        end
        chk("glitch_lvl_held", any_flip, 0);
        chk("glitch_saturate", glitch_cnt, 255);

        // Clear asserted on the very clock a glitch is rejected.
        cap_in = 1'b0;
        step(1);
        cap_in = 1'b1;
        step(2);
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        chk("glitch_clr_priority", glitch_cnt, 0);
        step(2);
        cap_in = 1'b0;
        step(1);
        cap_in = 1'b1;
        step(4);
        chk("glitch_count_one", glitch_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
